// File: rtl/mem_wb_elastic_register.sv
// MEM->WB pipeline stage register with valid/ready flow control.
// Holds RegWrite, MemtoReg, ReadData, ALUOut and WriteReg for the writeback
// stage. With SKID_ENABLE=1 a second (skid) entry absorbs one extra beat so
// ReadyM can be a flop with no combinational path from ReadyW. With
// SKID_ENABLE=0 the stage is a single entry with a combinational ReadyM.
// FlushM clears both entries synchronously; RST clears them asynchronously.
module mem_wb_elastic_register #(
  parameter int READ_DATA_WIDTH = 32,
  parameter int ALU_OUT_WIDTH   = 32,
  parameter int WRITE_REG_WIDTH = 5,
  parameter int SKID_ENABLE     = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FlushM,
  input  logic                       ValidM,
  output logic                       ReadyM,
  input  logic                       RegWriteM,
  input  logic                       MemtoRegM,
  input  logic [READ_DATA_WIDTH-1:0] ReadDataM,
  input  logic [ALU_OUT_WIDTH-1:0]   ALUOutM,
  input  logic [WRITE_REG_WIDTH-1:0] WriteRegM,
  output logic                       ValidW,
  input  logic                       ReadyW,
  output logic                       RegWriteW,
  output logic                       RegWriteEnW,
  output logic                       MemtoRegW,
  output logic [READ_DATA_WIDTH-1:0] ReadDataW,
  output logic [ALU_OUT_WIDTH-1:0]   ALUOutW,
  output logic [WRITE_REG_WIDTH-1:0] WriteRegW
);

  // Packed payload: {RegWrite, MemtoReg, ReadData, ALUOut, WriteReg}
  localparam int PW = 2 + READ_DATA_WIDTH + ALU_OUT_WIDTH + WRITE_REG_WIDTH;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q, ready_d;
  logic [PW-1:0] main_data_q, main_data_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic [PW-1:0] in_data_s;
  logic          ready_m_s;
  logic          accept_s;
  logic          consume_s;

  assign in_data_s = {RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WriteRegM};

  // Upstream ready: registered in skid mode, combinational in single-entry mode
  always_comb begin
    if (SKID_ENABLE != 0) begin
      ready_m_s = ready_q;
    end else begin
      ready_m_s = ReadyW | ~main_valid_q;
    end
  end

  assign accept_s  = ValidM & ready_m_s;
  assign consume_s = main_valid_q & ReadyW;

  // Next-state for main/skid entries; flush wins over any accept
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (FlushM) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (!main_valid_q) begin
      // Empty stage: a new entry goes straight to main
      if (accept_s) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_s;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (consume_s) begin
      // Main is leaving: refill from skid first to keep FIFO order
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        main_data_d  = in_data_s;
      end else begin
        // Payload kept as last consumed value; only the valid bit drops
        main_valid_d = 1'b0;
      end
    end else begin
      // Main stalled: a new entry parks in the skid slot
      if (accept_s && (SKID_ENABLE != 0)) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    ready_d = ~skid_valid_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign {RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW} = main_data_q;
  assign ValidW      = main_valid_q;
  assign RegWriteEnW = main_valid_q & main_data_q[PW-1];
  assign ReadyM      = ready_m_s;

endmodule

// File: tb/tb_mem_wb_elastic_register.sv
// Directed bench for mem_wb_elastic_register: a skid-mode instance driven by
// a vector table plus hand-written reset sequences, and a single-entry
// instance checked against a small handshake model.
module tb_mem_wb_elastic_register;

  logic        CLK = 1'b0;
  logic        RST;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Skid-mode instance signals
  logic        FlushM, ValidM, ReadyM, RegWriteM, MemtoRegM;
  logic [31:0] ReadDataM, ALUOutM;
  logic [4:0]  WriteRegM;
  logic        ValidW, ReadyW, RegWriteW, RegWriteEnW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  // Single-entry instance signals
  logic        FlushM0, ValidM0, ReadyM0, RegWriteM0, MemtoRegM0;
  logic [31:0] ReadDataM0, ALUOutM0;
  logic [4:0]  WriteRegM0;
  logic        ValidW0, ReadyW0, RegWriteW0, RegWriteEnW0, MemtoRegW0;
  logic [31:0] ReadDataW0, ALUOutW0;
  logic [4:0]  WriteRegW0;

  always #5 CLK = ~CLK;

  mem_wb_elastic_register #(.SKID_ENABLE(1)) dut (
    .CLK(CLK), .RST(RST), .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ReadDataM(ReadDataM),
    .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .ValidW(ValidW), .ReadyW(ReadyW),
    .RegWriteW(RegWriteW), .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  mem_wb_elastic_register #(.SKID_ENABLE(0)) dut0 (
    .CLK(CLK), .RST(RST), .FlushM(FlushM0), .ValidM(ValidM0), .ReadyM(ReadyM0),
    .RegWriteM(RegWriteM0), .MemtoRegM(MemtoRegM0), .ReadDataM(ReadDataM0),
    .ALUOutM(ALUOutM0), .WriteRegM(WriteRegM0), .ValidW(ValidW0), .ReadyW(ReadyW0),
    .RegWriteW(RegWriteW0), .RegWriteEnW(RegWriteEnW0), .MemtoRegW(MemtoRegW0),
    .ReadDataW(ReadDataW0), .ALUOutW(ALUOutW0), .WriteRegW(WriteRegW0)
  );

  typedef struct {
    logic        flush;
    logic        vm;
    logic        rw;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        vw_e;
    logic        rm_e;
    logic [31:0] alu_e;
    logic [4:0]  wr_e;
  } vec_t;

  vec_t vecs[21];

  // Read data is derived from ALUOut so a zero entry stays all-zero
  function automatic logic [31:0] f_rd(input logic [31:0] a);
    return {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vm, input logic rw,
                       input logic [31:0] alu, input logic [4:0] wr);
    FlushM    = fl;
    ValidM    = vm;
    ReadyW    = rw;
    ALUOutM   = alu;
    WriteRegM = wr;
    ReadDataM = f_rd(alu);
    RegWriteM = alu[0];
    MemtoRegM = alu[1];
  endtask

  task automatic chk_w(input string tag, input logic vw, input logic rm,
                       input logic [31:0] alu, input logic [4:0] wr);
    chk({tag, " ValidW"},      {31'd0, ValidW},      {31'd0, vw});
    chk({tag, " ReadyM"},      {31'd0, ReadyM},      {31'd0, rm});
    chk({tag, " ALUOutW"},     ALUOutW,              alu);
    chk({tag, " WriteRegW"},   {27'd0, WriteRegW},   {27'd0, wr});
    chk({tag, " ReadDataW"},   ReadDataW,            f_rd(alu));
    chk({tag, " RegWriteW"},   {31'd0, RegWriteW},   {31'd0, alu[0]});
    chk({tag, " MemtoRegW"},   {31'd0, MemtoRegW},   {31'd0, alu[1]});
    chk({tag, " RegWriteEnW"}, {31'd0, RegWriteEnW}, {31'd0, vw & alu[0]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        m_valid;
    logic        exp_ready;
    logic [31:0] send_val;
    logic [31:0] exp_cons;

    // Streaming: 8 entries, one per cycle
    for (int i = 1; i <= 8; i++) begin
      vecs[i-1] = '{1'b0, 1'b1, 1'b1, 32'(i), 5'(7 + i), 1'b1, 1'b1, 32'(i), 5'(7 + i)};
    end
    // Drain: payload of the consumed entry stays visible with ValidW=0
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0,  1'b0, 1'b1, 32'h8,  5'd15};
    // Backpressure: A into main, B into skid, C refused while skid full
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h11, 5'd1,  1'b1, 1'b1, 32'h11, 5'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h22, 5'd2,  1'b1, 1'b0, 32'h11, 5'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h33, 5'd3,  1'b1, 1'b0, 32'h11, 5'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0,  1'b1, 1'b1, 32'h22, 5'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0,  1'b0, 1'b1, 32'h22, 5'd2};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h33, 5'd3,  1'b1, 1'b1, 32'h33, 5'd3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0,  1'b0, 1'b1, 32'h33, 5'd3};
    // Flush collision: AA in main, BB in skid, CC offered with FlushM
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'hAA, 5'd10, 1'b1, 1'b1, 32'hAA, 5'd10};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 32'hBB, 5'd11, 1'b1, 1'b0, 32'hAA, 5'd10};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'hCC, 5'd12, 1'b0, 1'b1, 32'h0,  5'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,  5'd0,  1'b0, 1'b1, 32'h0,  5'd0};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h0,  5'd0,  1'b0, 1'b1, 32'h0,  5'd0};

    FlushM0 = 1'b0; ValidM0 = 1'b0; ReadyW0 = 1'b0; RegWriteM0 = 1'b1;
    MemtoRegM0 = 1'b0; ReadDataM0 = 32'h0; ALUOutM0 = 32'h0; WriteRegM0 = 5'd4;

    // Reset held 3 cycles with random inputs
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 32'($urandom), 5'($urandom));
      @(posedge CLK);
    end
    #1;
    chk_w("reset", 1'b0, 1'b1, 32'h0, 5'd0);
    chk("reset dut0 ValidW", {31'd0, ValidW0}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    @(posedge CLK); #1;
    chk_w("post-reset", 1'b0, 1'b1, 32'h0, 5'd0);

    // Vector table
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      drive(vecs[i].flush, vecs[i].vm, vecs[i].rw, vecs[i].alu, vecs[i].wr);
      @(posedge CLK); #1;
      chk_w($sformatf("vec%0d", i), vecs[i].vw_e, vecs[i].rm_e, vecs[i].alu_e, vecs[i].wr_e);
    end

    // Async reset mid-operation with both entries full
    @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 32'h55, 5'd5);
    @(posedge CLK); #1;
    @(negedge CLK); drive(1'b0, 1'b1, 1'b0, 32'h66, 5'd6);
    @(posedge CLK); #1;
    chk("full before async ReadyM", {31'd0, ReadyM}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    #2 RST = 1'b0;
    #1;
    chk_w("async reset", 1'b0, 1'b1, 32'h0, 5'd0);
    RST = 1'b1;
    @(negedge CLK); drive(1'b0, 1'b1, 1'b1, 32'h77, 5'd7);
    @(posedge CLK); #1;
    chk_w("after async", 1'b1, 1'b1, 32'h77, 5'd7);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h0, 5'd0);

    // Single-entry mode: ReadyW toggling 1,0,1,0 with ValidM held high
    m_valid  = 1'b0;
    send_val = 32'd1;
    exp_cons = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      ReadyW0  = ~i[0];
      ValidM0  = 1'b1;
      ALUOutM0 = send_val;
      #1;
      exp_ready = ReadyW0 | ~m_valid;
      chk($sformatf("se%0d ReadyM", i), {31'd0, ReadyM0}, {31'd0, exp_ready});
      chk($sformatf("se%0d ValidW", i), {31'd0, ValidW0}, {31'd0, m_valid});
      if (m_valid && ReadyW0) begin
        chk($sformatf("se%0d consumed", i), ALUOutW0, exp_cons);
        exp_cons = exp_cons + 32'd1;
      end
      @(posedge CLK);
      if (exp_ready) begin
        send_val = send_val + 32'd1;
        m_valid  = 1'b1;
      end
    end
    @(negedge CLK);
    ValidM0 = 1'b0;
    chk("se consumed count", exp_cons, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
